// File: rtl/ghr_ckpt_ctrl.sv
// GHR checkpoint controller: in-order checkpoint allocation at predict, in-order retirement at
// resolve, and a one-cycle corrected-GHR restore pulse on an accepted mispredict.
module ghr_ckpt_ctrl #(
  parameter int unsigned GH_W  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ID_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  input  logic [GH_W-1:0] alloc_gh,
  output logic [ID_W-1:0] alloc_id,
  input  logic            resolve_valid,
  input  logic [ID_W-1:0] resolve_id,
  input  logic            resolve_mis,
  input  logic            resolve_taken,
  input  logic            flush,
  output logic            restore_valid,
  output logic [GH_W-1:0] restore_gh,
  output logic [ID_W:0]   count,
  output logic            empty,
  output logic            err
);

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] head_q, head_d;
  logic [ID_W-1:0] tail_q, tail_d;
  logic [ID_W:0]   count_q, count_d;
  logic            restore_valid_q, restore_valid_d;
  logic [GH_W-1:0] restore_gh_q, restore_gh_d;
  logic            err_q, err_d;
  logic [GH_W-1:0] snap_q [DEPTH];

  logic alloc_fire;
  logic res_in_run;
  logic res_acc;
  logic res_rej;
  logic res_mis;
  logic snap_we;

  assign alloc_ready = (state_q == StRun) && (count_q < (ID_W+1)'(DEPTH));
  assign alloc_id    = tail_q;
  assign empty       = (count_q == '0);
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign res_in_run = resolve_valid && (state_q == StRun);
  assign res_acc    = res_in_run && (count_q != '0) && (resolve_id == head_q);
  assign res_rej    = res_in_run && !((count_q != '0) && (resolve_id == head_q));
  assign res_mis    = res_acc && resolve_mis;
  // A mispredict squashes everything younger, including a same-cycle allocation.
  assign snap_we    = alloc_fire && !flush && !res_mis;

  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    restore_valid_d = 1'b0;
    restore_gh_d    = restore_gh_q;
    err_d           = err_q;

    if (flush) begin
      tail_d  = head_q;
      count_d = '0;
      state_d = StRun;
    end else begin
      if (state_q == StRecover) begin
        state_d = StRun;
      end
      if (res_rej) begin
        err_d = 1'b1;
      end
      if (res_mis) begin
        head_d          = head_q + ID_W'(1);
        tail_d          = head_q + ID_W'(1);
        count_d         = '0;
        restore_valid_d = 1'b1;
        restore_gh_d    = {snap_q[head_q][GH_W-2:0], resolve_taken};
        state_d         = StRecover;
      end else begin
        if (res_acc) begin
          head_d = head_q + ID_W'(1);
        end
        if (alloc_fire) begin
          tail_d = tail_q + ID_W'(1);
        end
        if (alloc_fire && !res_acc) begin
          count_d = count_q + (ID_W+1)'(1);
        end else if (res_acc && !alloc_fire) begin
          count_d = count_q - (ID_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StRun;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      restore_valid_q <= 1'b0;
      restore_gh_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      restore_valid_q <= restore_valid_d;
      restore_gh_q    <= restore_gh_d;
      err_q           <= err_d;
    end
  end

  // Snapshot storage carries no reset; only entries between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (snap_we) begin
      snap_q[tail_q] <= alloc_gh;
    end
  end

  assign restore_valid = restore_valid_q;
  assign restore_gh    = restore_gh_q;
  assign count         = count_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ghr_ckpt_ctrl.sv
// Directed self-checking bench for ghr_ckpt_ctrl with hand-computed expectations.
module tb_ghr_ckpt_ctrl;

  localparam int unsigned GH_W  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned ID_W  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [GH_W-1:0] alloc_gh;
  logic [ID_W-1:0] alloc_id;
  logic            resolve_valid;
  logic [ID_W-1:0] resolve_id;
  logic            resolve_mis;
  logic            resolve_taken;
  logic            flush;
  logic            restore_valid;
  logic [GH_W-1:0] restore_gh;
  logic [ID_W:0]   count;
  logic            empty;
  logic            err;

  int n_checks = 0;
  int n_errors = 0;

  ghr_ckpt_ctrl #(.GH_W(GH_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_gh      (alloc_gh),
    .alloc_id      (alloc_id),
    .resolve_valid (resolve_valid),
    .resolve_id    (resolve_id),
    .resolve_mis   (resolve_mis),
    .resolve_taken (resolve_taken),
    .flush         (flush),
    .restore_valid (restore_valid),
    .restore_gh    (restore_gh),
    .count         (count),
    .empty         (empty),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid   = 1'b0;
    alloc_gh      = '0;
    resolve_valid = 1'b0;
    resolve_id    = '0;
    resolve_mis   = 1'b0;
    resolve_taken = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [GH_W-1:0] gh);
    alloc_valid = 1'b1;
    alloc_gh    = gh;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic resolve(input logic [ID_W-1:0] id, input logic mis, input logic taken);
    resolve_valid = 1'b1;
    resolve_id    = id;
    resolve_mis   = mis;
    resolve_taken = taken;
    tick();
    resolve_valid = 1'b0;
    resolve_mis   = 1'b0;
    resolve_taken = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_restore_valid", restore_valid, 0);
    check("rst_restore_gh", restore_gh, 0);
    check("rst_err", err, 0);
    check("rst_alloc_id", alloc_id, 0);

    // In-order allocate and retire without mispredicts.
    for (int i = 0; i < 3; i++) begin
      check("t1_alloc_id", alloc_id, i);
      alloc(GH_W'(i + 1));
    end
    check("t1_count3", count, 3);
    for (int i = 0; i < 3; i++) begin
      resolve(ID_W'(i), 1'b0, 1'b0);
      check("t1_no_restore", restore_valid, 0);
    end
    check("t1_count0", count, 0);
    check("t1_empty", empty, 1);
    check("t1_err", err, 0);

    // Mispredict restore: snap[1]=0xA1, taken=1 gives 0x143.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(GH_W'(32'hA0 + i));
    check("t2_count4", count, 4);
    resolve(0, 1'b0, 1'b0);
    check("t2_count3", count, 3);
    resolve(1, 1'b1, 1'b1);
    check("t2_restore_valid", restore_valid, 1);
    check("t2_restore_gh", restore_gh, 32'h0000_0143);
    check("t2_count", count, 0);
    check("t2_ready_recover", alloc_ready, 0);
    tick();
    check("t2_restore_pulse_end", restore_valid, 0);
    check("t2_ready_run", alloc_ready, 1);
    check("t2_next_id", alloc_id, 2);
    check("t2_gh_held", restore_gh, 32'h0000_0143);

    // Full queue, simultaneous alloc and retire, then pointer wrap.
    do_reset();
    for (int i = 0; i < 16; i++) alloc(GH_W'(i));
    check("t3_count16", count, 16);
    check("t3_full_not_ready", alloc_ready, 0);
    check("t3_full_id_wrapped", alloc_id, 0);
    alloc_valid   = 1'b1;
    alloc_gh      = 32'hBEEF;
    resolve(0, 1'b0, 1'b0);
    check("t3_count15", count, 15);
    check("t3_ready_after_free", alloc_ready, 1);
    check("t3_alloc_id_wrap", alloc_id, 0);
    tick();
    alloc_valid = 1'b0;
    check("t3_count16_again", count, 16);
    check("t3_alloc_id_1", alloc_id, 1);

    // Same-cycle alloc and mispredict of the sole entry: alloc is dropped.
    do_reset();
    alloc(32'h55);
    alloc_valid = 1'b1;
    alloc_gh    = 32'h77;
    resolve(0, 1'b1, 1'b0);
    alloc_valid = 1'b0;
    check("t4_count", count, 0);
    check("t4_tail", alloc_id, 1);
    check("t4_restore_valid", restore_valid, 1);
    check("t4_restore_gh", restore_gh, 32'hAA);
    tick();
    check("t4_pulse_end", restore_valid, 0);
    // Next checkpoint lands in slot 1 and restores from the new snapshot.
    alloc(32'h99);
    resolve(1, 1'b1, 1'b1);
    check("t4_restore_gh2", restore_gh, 32'h133);

    // Out-of-order and empty resolves set a sticky error.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(GH_W'(i));
    resolve(3, 1'b0, 1'b0);
    check("t5_err_ooo", err, 1);
    check("t5_count_unch", count, 4);
    check("t5_tail_unch", alloc_id, 4);
    tick();
    check("t5_err_sticky", err, 1);
    for (int i = 0; i < 4; i++) resolve(ID_W'(i), 1'b0, 1'b0);
    check("t5_head_unch_then_drain", count, 0);
    resolve(0, 1'b0, 1'b0);
    check("t5_err_empty_sticky", err, 1);
    do_reset();
    resolve(0, 1'b0, 1'b0);
    check("t5_err_empty_fresh", err, 1);
    check("t5_count_empty", count, 0);

    // Resolve during RECOVER is ignored without setting err.
    do_reset();
    alloc(32'h1);
    alloc(32'h2);
    resolve(0, 1'b1, 1'b0);
    resolve(1, 1'b0, 1'b0);
    check("t5_recover_ignore_err", err, 0);

    // Flush beats a same-cycle mispredict.
    do_reset();
    alloc(32'h10);
    alloc(32'h20);
    flush = 1'b1;
    resolve(0, 1'b1, 1'b1);
    flush = 1'b0;
    check("t6_flush_no_restore", restore_valid, 0);
    check("t6_flush_count", count, 0);
    check("t6_flush_ready", alloc_ready, 1);
    check("t6_flush_gh_unch", restore_gh, 0);
    check("t6_flush_tail", alloc_id, 0);
    check("t6_flush_err", err, 0);

    // Asynchronous reset in the middle of RECOVER.
    alloc(32'h80);
    resolve(0, 1'b1, 1'b1);
    check("t6_recover_pulse", restore_valid, 1);
    check("t6_recover_gh", restore_gh, 32'h101);
    #2;
    rst = 1'b1;
    #1;
    check("t6_arst_restore_valid", restore_valid, 0);
    check("t6_arst_restore_gh", restore_gh, 0);
    check("t6_arst_count", count, 0);
    check("t6_arst_alloc_id", alloc_id, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_arst_ready", alloc_ready, 1);
    check("t6_arst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ghr_ckpt_ctrl.md
Name: ghr_ckpt_ctrl

Overview:
Checkpoint controller for the global history register (GHR) in the branch predictor.
- Predict stage: allocates an in-order checkpoint ID for each predicted branch and stores the pre-update GHR snapshot.
- EX stage: retires checkpoints in program order as branches resolve.
- On a misprediction: flushes all younger checkpoints and issues a one-cycle restore of the corrected GHR to the predictor front end.

Parameters:
GH_W, 32, GHR width in bits
DEPTH, 16, checkpoint entries; power of 2, at least 2
ID_W, 4, checkpoint ID width; equals log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
alloc_valid  in  1  predict stage has a branch needing a checkpoint
alloc_ready  out  1  checkpoint slot available
alloc_gh  in  GH_W  GHR value before this branch's predicted shift
alloc_id  out  ID_W  ID assigned to the current alloc (tail pointer)
resolve_valid  in  1  EX stage resolves a branch
resolve_id  in  ID_W  checkpoint ID of the resolving branch
resolve_mis  in  1  resolving branch was mispredicted
resolve_taken  in  1  actual branch direction
flush  in  1  external pipeline flush (exception/ertn); drops all checkpoints
restore_valid  out  1  one-cycle pulse: predictor loads restore_gh
restore_gh  out  GH_W  corrected GHR
count  out  ID_W+1  live checkpoints
empty  out  1  count==0
err  out  1  sticky: out-of-order or empty resolve seen

Behaviour:
- Storage: DEPTH x GH_W snapshot array; head and tail pointers of ID_W bits, wrapping mod DEPTH; count register.
- FSM has two states, RUN and RECOVER.
  - Reset state is RUN.
  - RUN -> RECOVER on an accepted mispredict.
  - RECOVER -> RUN unconditionally after 1 cycle.
  - Any state -> RUN on flush.
- alloc_ready is driven by (state==RUN) && (count<DEPTH) only. There is no combinational path from resolve_* or flush.
- alloc_fire = alloc_valid && alloc_ready. On fire:
  - snap[tail] <= alloc_gh
  - tail <= tail+1
  - count +1
- alloc_id = tail, combinational.
- Accepted resolve: resolve_valid && state==RUN && count!=0 && resolve_id==head.
- Correct accepted resolve:
  - head <= head+1
  - count -1
  - If it coincides with alloc_fire, count is unchanged and both pointers advance.
- Mispredicting accepted resolve:
  - head <= head+1, tail <= head+1, count <= 0; all younger entries are discarded.
  - A same-cycle alloc_fire is discarded: no write to snap, no tail increment.
  - restore_gh <= {snap[head][GH_W-2:0], resolve_taken}, registered.
  - restore_valid is high for exactly the next cycle, i.e. 1-cycle latency from the resolve edge.
  - state -> RECOVER.
- RECOVER: alloc_ready=0; resolve_valid is ignored and does not set err.
- Rejected resolve in RUN (count==0 or resolve_id!=head): state is unchanged and err <= 1, sticky until reset.
- flush has the highest priority:
  - tail <= head, count <= 0, state <= RUN.
  - restore_valid is forced to 0 in the following cycle, even if a mispredict occurred in the same cycle.
  - flush does not change restore_gh and does not set err.
  - Same-cycle alloc_fire and resolve are discarded.
- Full: at count==DEPTH, alloc_ready=0. A correct resolve in that cycle frees a slot visible the next cycle.
- Reset (asserted at any time, including mid-RECOVER):
  - head=tail=0, count=0, state=RUN.
  - restore_valid=0, restore_gh=0, err=0.
  - alloc_ready=1 and empty=1 once reset is released.
  - snap contents are not reset.
- Outputs restore_valid, restore_gh, count and err are registered; alloc_ready, alloc_id and empty are combinational from registers.

Test Plan:
1. Reset, then 3 allocs with alloc_gh=0x1,0x2,0x3 -> alloc_id 0,1,2; count=3. Resolve IDs 0,1,2 with resolve_mis=0 -> count=0, empty=1, restore_valid never high.
2. Alloc 4 entries with gh=0xA0..0xA3, then resolve id 1 mispredicted with taken=1 after resolving id 0 -> restore_valid pulses 1 cycle with restore_gh=0x00000143; count=0; alloc_ready=0 that cycle. Next alloc gets alloc_id=2.
3. Fill 16 entries -> alloc_ready=0 at count=16. Same-cycle alloc_valid plus correct resolve of head -> no alloc that cycle, alloc accepted next cycle with alloc_id=0 (wrap).
4. Same-cycle alloc_fire and mispredicting resolve of the sole entry -> alloc discarded, count=0, tail=head=1, restore_valid pulses.
5. Resolve id 3 while head=0 -> err=1 and stays 1, pointers unchanged. Resolve with count=0 -> err stays 1.
6. Mispredict and flush in the same cycle -> restore_valid stays 0, count=0, state RUN. Assert rst during RECOVER -> all outputs return to reset values immediately (asynchronously).
